// File: rtl/mem_arb_pkg.sv
// Shared definitions for the block-RAM port arbiter: requester indices,
// lock state encoding and the priority-select helper used by the picker.
package mem_arb_pkg;

    localparam int NUM_REQ   = 3;
    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_STACK = 2;

    // Grant pattern that owns the port while a read-modify-write lock is held
    localparam logic [2:0] DATA_ONLY = 3'b010;

    typedef enum logic [0:0] {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_t;

    // Lowest-index requester that is both requesting and inside the mask wins
    function automatic logic [2:0] prio_select(input logic [2:0] req,
                                               input logic [2:0] mask);
        logic [2:0] cand;
        logic [2:0] pick;
        cand = req & mask;
        pick = 3'b000;
        if (cand[0]) begin
            pick = 3'b001;
        end else if (cand[1]) begin
            pick = 3'b010;
        end else if (cand[2]) begin
            pick = 3'b100;
        end
        return pick;
    endfunction

    // Index of the set bit of a one-hot grant (0 when empty)
    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[2]) begin
            idx = 2'd2;
        end else if (oh[1]) begin
            idx = 2'd1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational one-hot picker over three requesters. The base input names
// the requester with highest priority; priority then wraps upward from it.
module arb_prio_pick
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] base,
    output logic [2:0] gnt
);

    logic [2:0] upper_mask;

    // Split requesters into those at/above base and those below, upper half first
    always_comb begin
        case (base)
            2'd1:    upper_mask = 3'b110;
            2'd2:    upper_mask = 3'b100;
            default: upper_mask = 3'b111;
        endcase
        if (|(req & upper_mask)) begin
            gnt = prio_select(req, upper_mask);
        end else begin
            gnt = prio_select(req, ~upper_mask);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port block-RAM arbiter for fetch, data load/store and stack access.
// Grants one access per cycle, returns read data to its owner one cycle later,
// and supports a data-port lock for atomic read-modify-write sequences.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN replaces the fixed
// data > stack > fetch priority and its fetch starvation counter with a
// rotating round-robin pointer.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [2:0]          req,
    input  logic [2:0]          we,
    input  logic [3*ADDR_W-1:0] addr,
    input  logic [3*DATA_W-1:0] wdata,
    input  logic                lock,
    output logic [2:0]          gnt,
    output logic [2:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_wren,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                starved
);

    lock_state_t        lock_state;
    lock_state_t        lock_state_next;
    logic [2:0]         elig_req;
    logic [2:0]         pick_gnt;
    logic [2:0]         gnt_int;
    logic [1:0]         pick_base;
    logic [1:0]         gnt_idx;
    logic               any_gnt;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_we;
    logic [ADDR_W-1:0]  last_addr;
    logic [DATA_W-1:0]  last_wdata;
    logic [2:0]         read_owner;

    // While locked only the data port may compete for the RAM
    always_comb begin
        elig_req = req;
        if (lock_state == LOCK_LOCKED) begin
            elig_req = req & DATA_ONLY;
        end
    end

    arb_prio_pick u_pick (
        .req  (elig_req),
        .base (pick_base),
        .gnt  (pick_gnt)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN

    logic [1:0] rr_ptr;

    assign pick_base = rr_ptr;
    assign starved   = 1'b0;

    // Round-robin mode uses the rotating picker result directly
    always_comb begin
        gnt_int = pick_gnt;
    end

    // The requester after the one just granted becomes highest priority
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= 2'd0;
        end else if (any_gnt) begin
            case (gnt_idx)
                2'd0:    rr_ptr <= 2'd1;
                2'd1:    rr_ptr <= 2'd2;
                default: rr_ptr <= 2'd0;
            endcase
        end
    end

`else

    localparam logic [3:0] STARVE_THRESH = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       starve_hit;

    assign pick_base  = 2'(REQ_DATA);
    assign starve_hit = (starve_cnt >= STARVE_THRESH);
    assign starved    = starve_hit;

    // A fetch denied too long overrides the data-first order, unless locked
    always_comb begin
        gnt_int = pick_gnt;
        if ((lock_state == LOCK_UNLOCKED) && starve_hit && req[REQ_FETCH]) begin
            gnt_int = 3'b001;
        end
    end

    // Count consecutive denied fetch cycles, saturating, including locked cycles
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= 4'd0;
        end else if (req[REQ_FETCH] && !gnt[REQ_FETCH]) begin
            if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end

`endif

    // No grant may leave the block while reset is asserted
    always_comb begin
        gnt = resetn ? gnt_int : 3'b000;
    end

    assign any_gnt = |gnt;
    assign gnt_idx = onehot_to_idx(gnt);

    // Route the granted requester's command fields toward the RAM
    always_comb begin
        case (gnt_idx)
            2'd1: begin
                sel_addr  = addr[ADDR_W +: ADDR_W];
                sel_wdata = wdata[DATA_W +: DATA_W];
                sel_we    = we[1];
            end
            2'd2: begin
                sel_addr  = addr[2*ADDR_W +: ADDR_W];
                sel_wdata = wdata[2*DATA_W +: DATA_W];
                sel_we    = we[2];
            end
            default: begin
                sel_addr  = addr[0 +: ADDR_W];
                sel_wdata = wdata[0 +: DATA_W];
                sel_we    = we[0];
            end
        endcase
    end

    // Drive the RAM command; address and data hold when the port is idle
    always_comb begin
        ram_addr  = last_addr;
        ram_wdata = last_wdata;
        ram_wren  = 1'b0;
        if (any_gnt) begin
            ram_addr  = sel_addr;
            ram_wdata = sel_wdata;
            ram_wren  = sel_we;
        end
    end

    // Remember the last issued address and data for the idle hold
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_addr  <= '0;
            last_wdata <= '0;
        end else if (any_gnt) begin
            last_addr  <= sel_addr;
            last_wdata <= sel_wdata;
        end
    end

    // Track which requester owns the read returning next cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            read_owner <= 3'b000;
        end else begin
            read_owner <= gnt & ~we;
        end
    end

    assign rvalid = read_owner;
    assign rdata  = (|read_owner) ? ram_rdata : '0;

    // Lock is taken on a locked data grant and released when data lets go
    always_comb begin
        lock_state_next = lock_state;
        case (lock_state)
            LOCK_UNLOCKED: begin
                if (gnt[REQ_DATA] && lock) begin
                    lock_state_next = LOCK_LOCKED;
                end
            end
            default: begin
                if (!lock || !req[REQ_DATA]) begin
                    lock_state_next = LOCK_UNLOCKED;
                end
            end
        endcase
    end

    // Lock state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lock_state <= LOCK_UNLOCKED;
        end else begin
            lock_state <= lock_state_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations followed by a randomized run against a behavioural model.
// Honours MEM_ARB_ROUND_ROBIN_EN the same way as the design.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 16;
    localparam int STARVE_LIMIT = 4;
    localparam int RAND_CYCLES  = 3000;

    logic                clock = 1'b0;
    logic                resetn = 1'b0;
    logic [2:0]          req = 3'b000;
    logic [2:0]          we = 3'b000;
    logic                lock = 1'b0;
    logic [ADDR_W-1:0]   r_addr [3];
    logic [DATA_W-1:0]   r_wdata [3];
    logic [3*ADDR_W-1:0] addr;
    logic [3*DATA_W-1:0] wdata;
    logic [2:0]          gnt;
    logic [2:0]          rvalid;
    logic [DATA_W-1:0]   rdata;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_wren;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata = '0;
    logic                starved;

    logic                poke_en = 1'b0;
    logic [8:0]          poke_addr = '0;
    logic [DATA_W-1:0]   poke_data = '0;
    logic [DATA_W-1:0]   ram_mem [512];

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model state
    logic [DATA_W-1:0]   m_mem [512];
    int                  m_cnt;
    bit                  m_locked;
    int                  m_ptr;
    logic [ADDR_W-1:0]   m_last_addr;
    logic [DATA_W-1:0]   m_last_wdata;
    logic [2:0]          m_rv;
    logic [DATA_W-1:0]   m_rd;

    assign addr  = {r_addr[2], r_addr[1], r_addr[0]};
    assign wdata = {r_wdata[2], r_wdata[1], r_wdata[0]};

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .lock      (lock),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_wren  (ram_wren),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .starved   (starved)
    );

    // Synchronous write-first RAM with a backdoor poke for preloading
    always @(posedge clock) begin
        if (poke_en) begin
            ram_mem[poke_addr] <= poke_data;
        end
        if (ram_wren) begin
            ram_mem[ram_addr[8:0]] <= ram_wdata;
            ram_rdata <= ram_wdata;
        end else begin
            ram_rdata <= ram_mem[ram_addr[8:0]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        req  = 3'b000;
        we   = 3'b000;
        lock = 1'b0;
    endtask

    task automatic setReq(input int i, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        req[i]     = 1'b1;
        we[i]      = w;
        r_addr[i]  = a;
        r_wdata[i] = d;
    endtask

    task automatic applyReset();
        resetn = 1'b0;
        idleInputs();
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    // Random requesters: hold until granted, then maybe issue a new access
    task automatic applyStimulus(input logic [2:0] granted);
        for (int i = 0; i < 3; i++) begin
            if (!req[i] || granted[i]) begin
                if ($urandom_range(0, 99) < 65) begin
                    setReq(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)),
                           16'($urandom));
                end else begin
                    req[i] = 1'b0;
                    we[i]  = 1'b0;
                end
            end
        end
        lock = req[1] && ($urandom_range(0, 2) != 0);
    endtask

    // Who should win this cycle, from the arbitration rules
    function automatic logic [2:0] modelGrant();
        int order [3];
        if (m_locked) begin
            return req[1] ? 3'b010 : 3'b000;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 3; k++) begin
            order[k] = (m_ptr + k) % 3;
        end
`else
        if (m_cnt >= STARVE_LIMIT && req[0]) begin
            return 3'b001;
        end
        order = '{1, 2, 0};
`endif
        for (int k = 0; k < 3; k++) begin
            if (req[order[k]]) begin
                return 3'(1 << order[k]);
            end
        end
        return 3'b000;
    endfunction

    function automatic int grantIndex(input logic [2:0] g);
        int idx;
        idx = -1;
        for (int i = 0; i < 3; i++) begin
            if (g[i]) idx = i;
        end
        return idx;
    endfunction

    // Advance the model across one rising edge given this cycle's grant
    task automatic modelUpdate(input logic [2:0] g);
        int idx;
        idx = grantIndex(g);
        m_rv = 3'b000;
        if (idx >= 0) begin
            m_last_addr  = r_addr[idx];
            m_last_wdata = r_wdata[idx];
            if (we[idx]) begin
                m_mem[r_addr[idx][8:0]] = r_wdata[idx];
            end else begin
                m_rv = g;
                m_rd = m_mem[r_addr[idx][8:0]];
            end
            m_ptr = (idx + 1) % 3;
        end
        if (req[0] && !g[0]) begin
            m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        end else begin
            m_cnt = 0;
        end
        if (!m_locked) begin
            m_locked = g[1] && lock;
        end else begin
            m_locked = req[1] && lock;
        end
    endtask

    task automatic compareCycle(input logic [2:0] g);
        int idx;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
        logic e_wren;
        idx = grantIndex(g);
        e_addr  = (idx >= 0) ? r_addr[idx] : m_last_addr;
        e_wdata = (idx >= 0) ? r_wdata[idx] : m_last_wdata;
        e_wren  = (idx >= 0) ? we[idx] : 1'b0;
        checkOutput("rand gnt", 32'(gnt), 32'(g));
        checkOutput("rand ram_addr", 32'(ram_addr), 32'(e_addr));
        checkOutput("rand ram_wdata", 32'(ram_wdata), 32'(e_wdata));
        checkOutput("rand ram_wren", 32'(ram_wren), 32'(e_wren));
        checkOutput("rand rvalid", 32'(rvalid), 32'(m_rv));
        if (m_rv != 3'b000) begin
            checkOutput("rand rdata", 32'(rdata), 32'(m_rd));
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        checkOutput("rand starved", 32'(starved), 32'(0));
`else
        checkOutput("rand starved", 32'(starved), 32'(m_cnt >= STARVE_LIMIT));
`endif
    endtask

    initial begin
        logic [2:0] exp_g;
        int wren_seen;

        for (int i = 0; i < 3; i++) begin
            r_addr[i]  = '0;
            r_wdata[i] = '0;
        end

        // Reset state, with a preload of 0xBEEF at 0x0010
        #3;
        checkOutput("reset gnt", 32'(gnt), 32'(0));
        checkOutput("reset rvalid", 32'(rvalid), 32'(0));
        checkOutput("reset ram_wren", 32'(ram_wren), 32'(0));
        checkOutput("reset ram_addr", 32'(ram_addr), 32'(0));
        checkOutput("reset ram_wdata", 32'(ram_wdata), 32'(0));
        checkOutput("reset starved", 32'(starved), 32'(0));
        poke_en = 1'b1;
        poke_addr = 9'h010;
        poke_data = 16'hBEEF;
        tick();
        poke_en = 1'b0;
        applyReset();

        // Lone fetch read
        setReq(0, 1'b0, 16'h0010, 16'h0000);
        @(negedge clock);
        checkOutput("fetch gnt", 32'(gnt), 32'(3'b001));
        checkOutput("fetch ram_addr", 32'(ram_addr), 32'(16'h0010));
        checkOutput("fetch ram_wren", 32'(ram_wren), 32'(0));
        tick();
        idleInputs();
        @(negedge clock);
        checkOutput("fetch rvalid", 32'(rvalid), 32'(3'b001));
        checkOutput("fetch rdata", 32'(rdata), 32'(16'hBEEF));

        // All three requesting continuously
        applyReset();
        for (int i = 0; i < 3; i++) setReq(i, 1'b0, 16'(i), 16'h0000);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checkOutput("rr gnt", 32'(gnt), 32'(3'(1 << (k % 3))));
            checkOutput("rr starved", 32'(starved), 32'(0));
            tick();
        end
`else
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checkOutput("starve gnt", 32'(gnt), (k < 4) ? 32'(3'b010) : 32'(3'b001));
            checkOutput("starve flag", 32'(starved), 32'(k == 4));
            tick();
        end
        @(negedge clock);
        checkOutput("starve cleared", 32'(starved), 32'(0));
        checkOutput("starve after gnt", 32'(gnt), 32'(3'b010));
`endif
        idleInputs();

        // Locked write/read of 0x0040 while stack waits
        applyReset();
        setReq(1, 1'b1, 16'h0040, 16'h1234);
        setReq(2, 1'b0, 16'h0005, 16'h0000);
        lock = 1'b1;
        @(negedge clock);
        checkOutput("lock wr gnt", 32'(gnt), 32'(3'b010));
        checkOutput("lock wr wren", 32'(ram_wren), 32'(1));
        checkOutput("lock wr data", 32'(ram_wdata), 32'(16'h1234));
        tick();
        setReq(1, 1'b0, 16'h0040, 16'h0000);
        @(negedge clock);
        checkOutput("lock rd gnt", 32'(gnt), 32'(3'b010));
        tick();
        req[1] = 1'b0;
        lock = 1'b0;
        @(negedge clock);
        checkOutput("lock drop gnt", 32'(gnt), 32'(3'b000));
        checkOutput("lock rvalid", 32'(rvalid), 32'(3'b010));
        checkOutput("lock rdata", 32'(rdata), 32'(16'h1234));
        tick();
        @(negedge clock);
        checkOutput("unlock stack gnt", 32'(gnt), 32'(3'b100));
        tick();
        idleInputs();

        // Reset pulse while a stack read is in flight
        applyReset();
        setReq(2, 1'b0, 16'h0005, 16'h0000);
        @(negedge clock);
        checkOutput("flight gnt", 32'(gnt), 32'(3'b100));
        tick();
        idleInputs();
        resetn = 1'b0;
        #1;
        checkOutput("pulse rvalid", 32'(rvalid), 32'(0));
        checkOutput("pulse ram_addr", 32'(ram_addr), 32'(0));
        checkOutput("pulse ram_wren", 32'(ram_wren), 32'(0));
        checkOutput("pulse starved", 32'(starved), 32'(0));
        #1;
        resetn = 1'b1;
        @(negedge clock);
        checkOutput("post-pulse rvalid", 32'(rvalid), 32'(0));
        tick();
        @(negedge clock);
        checkOutput("post-pulse rvalid2", 32'(rvalid), 32'(0));

        // Stack write then fetch read of the same address
        applyReset();
        wren_seen = 0;
        setReq(2, 1'b1, 16'h0100, 16'hCAFE);
        @(negedge clock);
        checkOutput("sw gnt", 32'(gnt), 32'(3'b100));
        checkOutput("sw ram_addr", 32'(ram_addr), 32'(16'h0100));
        wren_seen += int'(ram_wren);
        tick();
        idleInputs();
        setReq(0, 1'b0, 16'h0100, 16'h0000);
        @(negedge clock);
        checkOutput("fr gnt", 32'(gnt), 32'(3'b001));
        wren_seen += int'(ram_wren);
        tick();
        idleInputs();
        @(negedge clock);
        checkOutput("sw wren count", 32'(wren_seen), 32'(1));
        checkOutput("fr rvalid", 32'(rvalid), 32'(3'b001));
        checkOutput("fr rdata", 32'(rdata), 32'(16'hCAFE));

        // Randomized traffic against the behavioural model
        applyReset();
        for (int i = 0; i < 512; i++) m_mem[i] = ram_mem[i];
        m_cnt = 0;
        m_locked = 1'b0;
        m_ptr = 0;
        m_last_addr = '0;
        m_last_wdata = '0;
        m_rv = 3'b000;
        m_rd = '0;
        applyStimulus(3'b000);
        for (int c = 0; c < RAND_CYCLES && tests_failed < 40; c++) begin
            @(negedge clock);
            exp_g = modelGrant();
            compareCycle(exp_g);
            @(posedge clock);
            modelUpdate(exp_g);
            #1;
            applyStimulus(exp_g);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
